// File: rtl/sw_disp_pkg.sv
// Shared types and constants for the stopwatch display scanner.
package sw_disp_pkg;

  typedef enum logic [1:0] {
    LIVE     = 2'd0,
    LAP_AUTO = 2'd1,
    LAP_PIN  = 2'd2
  } view_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for digits 9 down to 0.
  localparam logic [9:0][6:0] GLYPH = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [2:0] IDX_MS1  = 3'd0;
  localparam logic [2:0] IDX_MS10 = 3'd1;
  localparam logic [2:0] IDX_S1   = 3'd2;
  localparam logic [2:0] IDX_S10  = 3'd3;
  localparam logic [2:0] IDX_M1   = 3'd4;
  localparam logic [2:0] IDX_M10  = 3'd5;

  localparam logic [5:0] DP_MASK = 6'b010100;

  function automatic logic [5:0] anode_low(input logic [2:0] idx);
    anode_low = ~(6'b000001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 and the
// blank input both produce a dark digit.
module bcd_to_seg7
  import sw_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (bcd <= 4'd9) begin
      seg = GLYPH[bcd];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/sw_display_scan.sv
// Multiplexes live or lap BCD time onto a 6-digit common-anode display.
// Optional build macro SW_DISP_LEAD_BLANK_EN blanks leading zero minute digits.
module sw_display_scan
  import sw_disp_pkg::*;
#(
  parameter int SCAN_DIV        = 8,
  parameter int LAP_HOLD_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cur_digits,
  input  logic [23:0] lap_digits,
  input  logic        btn_view,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        view_lap
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(LAP_HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(LAP_HOLD_FRAMES);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    idx_nx;
  logic [23:0]   snap;
  logic [23:0]   snap_nx;
  logic [23:0]   lap_prev;
  logic          btn_prev;
  view_t         state;
  view_t         state_nx;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_nx;
  logic          view_lap_nx;
  logic          slot_tick;
  logic          frame_tick;
  logic          btn_rise;
  logic          lap_chg;
  logic          lap_zero;
  logic [3:0]    nib;
  logic          blank;
  logic          dp_nx;
  logic [6:0]    seg_dec;

  assign slot_tick  = (cnt == CNT_LAST);
  assign frame_tick = slot_tick && (idx == IDX_M10);
  assign idx_nx     = (idx == IDX_M10) ? IDX_MS1 : idx + 3'd1;
  assign btn_rise   = btn_view & ~btn_prev;
  assign lap_chg    = (lap_digits != lap_prev);
  assign lap_zero   = (lap_digits == 24'd0);

  // The frame snapshot follows the view the FSM is moving into, so the first
  // digit of a new frame already shows the newly selected source.
  assign snap_nx = frame_tick ? (view_lap_nx ? lap_digits : cur_digits) : snap;
  assign nib     = snap_nx[{idx_nx, 2'b00} +: 4];

`ifdef SW_DISP_LEAD_BLANK_EN
  logic lead5;
  logic lead4;
  assign lead5 = (snap_nx[23:20] == 4'd0);
  assign lead4 = lead5 && (snap_nx[19:16] == 4'd0);
  assign blank = ((idx_nx == IDX_M10) && lead5) || ((idx_nx == IDX_M1) && lead4);
`else
  assign blank = 1'b0;
`endif

  assign dp_nx = ~DP_MASK[idx_nx] | blank;

  bcd_to_seg7 u_dec (
    .bcd   (nib),
    .blank (blank),
    .seg   (seg_dec)
  );

  // Scan divider, digit index, frame snapshot and input history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= IDX_MS1;
      snap     <= 24'd0;
      lap_prev <= 24'd0;
      btn_prev <= 1'b0;
    end else begin
      cnt      <= slot_tick ? '0 : cnt + CW'(1);
      lap_prev <= lap_digits;
      btn_prev <= btn_view;
      if (slot_tick) idx <= idx_nx;
      if (frame_tick) snap <= snap_nx;
    end
  end

  // Display drive registers, refreshed once per digit slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 6'h3F;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (slot_tick) begin
      an  <= anode_low(idx_nx);
      seg <= seg_dec;
      dp  <= dp_nx;
    end
  end

  // View FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LIVE;
      hold     <= '0;
      view_lap <= 1'b0;
    end else begin
      state    <= state_nx;
      hold     <= hold_nx;
      view_lap <= view_lap_nx;
    end
  end

  // View FSM next state: zero-lap clear beats the button, which beats a lap capture.
  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    if (lap_chg && lap_zero) begin
      state_nx = LIVE;
      hold_nx  = '0;
    end else if (btn_rise) begin
      case (state)
        LIVE:     state_nx = LAP_PIN;
        LAP_AUTO: begin
          state_nx = LAP_PIN;
          hold_nx  = '0;
        end
        LAP_PIN:  state_nx = LIVE;
        default:  begin
          state_nx = LIVE;
          hold_nx  = '0;
        end
      endcase
    end else if (lap_chg) begin
      if (state != LAP_PIN) begin
        state_nx = LAP_AUTO;
        hold_nx  = HOLD_LOAD;
      end else begin
        state_nx = LAP_PIN;
      end
    end else if ((state == LAP_AUTO) && frame_tick) begin
      if (hold <= HW'(1)) begin
        state_nx = LIVE;
        hold_nx  = '0;
      end else begin
        hold_nx = hold - HW'(1);
      end
    end else begin
      state_nx = state;
    end
  end

  // View FSM output.
  always_comb begin
    view_lap_nx = (state_nx != LIVE);
  end

endmodule

// File: tb/tb_sw_display_scan.sv
// Scoreboard bench for sw_display_scan: a cycle-counting reference model
// queues expected slot outputs and view flags; a monitor pops and compares.
module tb_sw_display_scan;

  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cur_digits = 24'd0;
  logic [23:0] lap_digits = 24'd0;
  logic        btn_view = 1'b0;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        view_lap;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  logic        vl_q[$];

  always #5 clk = ~clk;

  sw_display_scan #(.SCAN_DIV(SCAN_DIV), .LAP_HOLD_FRAMES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .cur_digits (cur_digits),
    .lap_digits (lap_digits),
    .btn_view   (btn_view),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .view_lap   (view_lap)
  );

  // Lit segments (active-high, bit0=a .. bit6=g) from the usual digit shapes.
  function automatic logic [6:0] glyph(input int d);
    logic [6:0] lit;
    case (d)
      0: lit = 7'b0111111;
      1: lit = 7'b0000110;
      2: lit = 7'b1011011;
      3: lit = 7'b1001111;
      4: lit = 7'b1100110;
      5: lit = 7'b1101101;
      6: lit = 7'b1111101;
      7: lit = 7'b0000111;
      8: lit = 7'b1111111;
      9: lit = 7'b1101111;
      default: lit = 7'b0000000;
    endcase
    return ~lit;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reference model: mode 0=live, 1=auto lap, 2=pinned lap.
  int          m_cyc;
  int          m_mode;
  int          m_left;
  logic [23:0] m_snap;
  logic [23:0] m_lap_prev;
  logic        m_btn_prev;

  initial begin
    int boundary, pos, frame, nib;
    logic chg, zero, rise, blk, edp;
    logic [6:0] eseg;
    logic [5:0] ean;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cyc = 0; m_mode = 0; m_left = 0;
        m_snap = 24'd0; m_lap_prev = 24'd0; m_btn_prev = 1'b0;
        exp_q.delete();
        vl_q.delete();
      end else begin
        boundary = ((m_cyc % SCAN_DIV) == SCAN_DIV - 1) ? 1 : 0;
        pos      = ((m_cyc / SCAN_DIV) + 1) % 6;
        frame    = (boundary != 0 && pos == 0) ? 1 : 0;
        chg  = (lap_digits != m_lap_prev);
        zero = (lap_digits == 24'd0);
        rise = btn_view && !m_btn_prev;
        if (chg && zero) begin
          m_mode = 0; m_left = 0;
        end else if (rise) begin
          if (m_mode == 2) m_mode = 0;
          else begin m_mode = 2; m_left = 0; end
        end else if (chg) begin
          if (m_mode != 2) begin m_mode = 1; m_left = HOLD; end
        end else if (m_mode == 1 && frame != 0) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 0;
        end
        if (frame != 0) m_snap = (m_mode != 0) ? lap_digits : cur_digits;
        if (boundary != 0) begin
          nib = int'((m_snap >> (4 * pos)) & 24'hF);
          blk = 1'b0;
`ifdef SW_DISP_LEAD_BLANK_EN
          if (pos == 5 && m_snap[23:20] == 4'd0) blk = 1'b1;
          if (pos == 4 && m_snap[23:16] == 8'd0) blk = 1'b1;
`endif
          eseg = blk ? 7'h7F : glyph(nib);
          edp  = (pos == 2 || pos == 4) ? 1'b0 : 1'b1;
          if (blk) edp = 1'b1;
          ean  = 6'h3F & ~(6'd1 << pos);
          exp_q.push_back({ean, eseg, edp});
        end
        vl_q.push_back(m_mode != 0);
        m_lap_prev = lap_digits;
        m_btn_prev = btn_view;
        m_cyc++;
      end
    end
  end

  // Monitor: view flag every cycle, display triple whenever the anode changes.
  initial begin
    logic [5:0]  an_prev;
    logic [13:0] e;
    logic        ev;
    an_prev = 6'h3F;
    forever begin
      @(negedge clk);
      if (rst) begin
        an_prev = 6'h3F;
      end else begin
        if (vl_q.size() == 0) begin
          check("view_q_empty", 32'd1, 32'd0);
        end else begin
          ev = vl_q.pop_front();
          check("view_lap", 32'(view_lap), 32'(ev));
        end
        if (an !== an_prev) begin
          if (exp_q.size() == 0) begin
            check("slot_q_empty", 32'(an), 32'h3F);
          end else begin
            e = exp_q.pop_front();
            check("an", 32'(an), 32'(e[13:8]));
            check("seg", 32'(seg), 32'(e[7:1]));
            check("dp", 32'(dp), 32'(e[0]));
          end
          an_prev = an;
        end
      end
    end
  end

  initial begin
    cycles(3);
    check("rst_an", 32'(an), 32'h3F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_view", 32'(view_lap), 32'd0);
    cur_digits = 24'h012345;
    rst = 1'b0;
    cycles(60);
    lap_digits = 24'h000512;
    cycles(80);
    lap_digits = 24'h000600;
    cycles(10);
    btn_view = 1'b1;
    cycles(3);
    btn_view = 1'b0;
    cycles(50);
    lap_digits = 24'h000733;
    cycles(50);
    btn_view = 1'b1;
    cycles(3);
    btn_view = 1'b0;
    cycles(30);
    btn_view = 1'b1;
    cycles(3);
    btn_view = 1'b0;
    cycles(10);
    btn_view = 1'b1;
    lap_digits = 24'h000000;
    cycles(30);
    btn_view = 1'b0;
    cur_digits = 24'h01234C;
    cycles(30);
    cycles(1);
    rst = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'h3F);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'd1);
    cycles(2);
    rst = 1'b0;
    cur_digits = 24'h003456;
    cycles(60);
    cur_digits = 24'h013456;
    cycles(60);
    for (int i = 0; i < 2500; i++) begin
      cycles(1);
      if ($urandom_range(19) == 0) cur_digits = 24'($urandom());
      if ($urandom_range(59) == 0) lap_digits = ($urandom_range(3) == 0) ? 24'd0 : 24'($urandom());
      if ($urandom_range(14) == 0) btn_view = ~btn_view;
      if ($urandom_range(699) == 0) begin
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
      end
    end
    cycles(2);
    check("slot_q_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
